// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Purpose:
//   Groups the CPU-side write port and the status/serial outputs of
//   uart_tx_fifo into a single bundle.
//
// Handshake:
//   wr_en/wr_data form a fire-and-forget write strobe.  A byte is taken when
//   wr_en=1 and full=0 at a rising clock edge.  When full=1 the byte is
//   dropped.  full is registered, so a writer may look at full in the same
//   cycle it raises wr_en with no combinational loop.
//
// Signals:
//   wr_en    master->slave  byte write strobe
//   wr_data  master->slave  byte to enqueue, sampled when wr_en=1
//   full     slave->master  FIFO holds FIFO_DEPTH bytes
//   level    slave->master  bytes queued, not counting the one being shifted
//   busy     slave->master  a frame is in progress or bytes are queued
//   tx       slave->master  serial line, idle high
//
// Modports:
//   master  the writer (CPU decode / testbench)
//   slave   the transmitter (uart_tx_fifo)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic [LW-1:0] level;
   logic          busy;
   logic          tx;

   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  level,
      input  busy,
      input  tx
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output level,
      output busy,
      output tx
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose:
//   8N1 UART transmitter fed by a small byte FIFO.  The CPU writes bytes with
//   a single-cycle strobe; the transmitter drains the FIFO one frame at a time
//   (start bit, 8 data bits LSB first, stop bit), each bit lasting exactly
//   CLKS_PER_BIT clock cycles.  Back-to-back frames are separated by a single
//   idle cycle, which is the cycle in which the next byte is popped.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit, >= 2
//   FIFO_DEPTH    byte entries in the FIFO, power of two, >= 2
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset; aborts any frame and flushes
//              the FIFO
//   bus        uart_tx_fifo_if.slave: wr_en, wr_data, full, level, busy, tx
//   dbg_state  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus,
   output logic [1:0]     dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   // ---------------------------------------------------------------------------
   // Storage and bookkeeping
   // ---------------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [LW-1:0] level_r;
   logic          full_r;

   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tx_r;

   logic          wr_accept;
   logic          pop;
   logic          baud_done;

   // full comes from the registered level only, so a write in the same
   // cycle as a pop is still dropped when the FIFO was full at the start of
   // the cycle.
   assign full_r    = (level_r == LVL_FULL);
   assign wr_accept = bus.wr_en && !full_r && !rst;

   // The transmitter only pops from IDLE; this is also the single idle
   // cycle between consecutive frames.
   assign pop       = (state == IDLE) && (level_r != '0);

   assign baud_done = (baud_cnt == BAUD_LAST);

   // ---------------------------------------------------------------------------
   // FIFO data array.  Contents need no reset: the pointers and level decide
   // what is valid.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[tail] <= bus.wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Tail pointer and level.  Pointers wrap naturally because FIFO_DEPTH is
   // a power of two.  A simultaneous write and pop leaves level unchanged.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tail    <= '0;
         level_r <= '0;
      end else begin
         if (wr_accept) begin
            tail <= tail + 1'b1;
         end
         case ({wr_accept, pop})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Transmit FSM.
   //
   // tx is registered and is loaded with the line value of the state being
   // entered, so the line changes on the same edge as the state.  The baud
   // counter is cleared on every state entry and on every bit boundary,
   // making each bit exactly CLKS_PER_BIT cycles and each frame exactly
   // 10*CLKS_PER_BIT cycles.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         head     <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx_r     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx_r     <= 1'b1;
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (pop) begin
                  shreg <= mem[head];
                  head  <= head + 1'b1;
                  state <= START;
                  tx_r  <= 1'b0;
               end
            end

            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx_r     <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_r  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_r    <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               tx_r <= 1'b1;
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               bit_idx  <= '0;
               tx_r     <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.full   = full_r;
   assign bus.level  = level_r;
   assign bus.busy   = (state != IDLE) || (level_r != '0);
   assign bus.tx     = tx_r;
   assign dbg_state  = state;

endmodule
